rca_32_bit: RTL and testbench
=============================

# rca_32_bit

32-bit ripple-carry adder with a registered result. It adds two 32-bit unsigned operands plus a 1-bit carry-in, producing a 32-bit sum and a carry-out. The arithmetic core is a chain of 32 one-bit full-adder cells. The sum and carry-out are captured in an output register, so the block can drop into a synchronous datapath as a one-cycle-latency adder stage.

## Interface

- Parameters: none. Width is fixed at 32 bits.
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- a  input  32  operand A, unsigned
- b  input  32  operand B, unsigned
- c_in  input  1  carry into bit 0
- s  output  32  registered sum, (a + b + c_in) mod 2^32
- c_out  output  1  registered carry out of bit 31

## Operation

- Core structure is 32 one-bit full-adder cells, instantiated via generate or explicitly.
  - Cell i: sum_i = a[i] ^ b[i] ^ c[i]
  - Cell i: c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]))
  - c[0] = c_in; carry-out of cell 31 = c[32].
- The full-adder cell is a separate small module. Do not implement the core with a single behavioural "+".
- Arithmetic rules:
  - {c_out, s} = a + b + c_in, computed as a 33-bit unsigned result.
  - No signed interpretation and no overflow flag.
  - Maximum result is 0xFFFFFFFF + 0xFFFFFFFF + 1, giving s = 0xFFFFFFFF, c_out = 1.
- Output register: on each rising clk edge with rst_n high, s <= sum[31:0] and c_out <= c[32].
- No enable and no valid handshake. A new result is captured on every cycle.
- Reset:
  - rst_n low forces s = 32'h0 and c_out = 0 immediately, independent of clk.
  - Outputs hold those values while rst_n stays low.
- No internal state other than the output register.

## Timing

- Latency is 1 cycle.
  - Inputs present before rising edge N appear on s/c_out after edge N.
  - Inputs must be stable for setup before the edge.
  - Throughput is one addition per cycle.
- Critical path runs through the 32-cell carry chain, from a[0]/b[0]/c_in to c[32] and then to the register. The clock period must cover the full ripple.
- Reset assertion:
  - Asynchronous; outputs clear within the same delta or cycle.
  - A reset asserted mid-operation discards the pending result.
- Reset release:
  - Synchronous in effect. The first capture happens on the first rising edge with rst_n high.
  - If rst_n rises coincident with a clk edge, the outputs stay 0 for that edge.
- Input changes between edges have no effect on the outputs.

## Test plan

- Basic addition, checked one cycle after each vector is applied:
  - Reset low, then release. Apply a=0x4, b=0x5, c_in=0 -> s=0x00000009, c_out=0.
  - Then a=0x4, b=0x5, c_in=1 -> s=0x0000000A, c_out=0.
  - Then a=0x6, b=0x7, c_in=0 -> s=0x0000000D, c_out=0.
  - Then a=0x6, b=0x7, c_in=1 -> s=0x0000000E, c_out=0.
- Full carry ripple and max values:
  - a=0xFFFFFFFF, b=0x0, c_in=1 -> s=0x00000000, c_out=1.
  - a=0xFFFFFFFF, b=0xFFFFFFFF, c_in=1 -> s=0xFFFFFFFF, c_out=1.
  - a=0x80000000, b=0x80000000, c_in=0 -> s=0x0, c_out=1.
- Latency and hold:
  - Change a/b mid-cycle without a clock edge -> s/c_out unchanged.
  - After the next edge -> the new sum appears.
  - Back-to-back vectors on consecutive edges -> one result per cycle, each delayed exactly 1 cycle.
- Asynchronous reset:
  - With s=0xE and c_out=0 held, drop rst_n between edges -> s=0x0 and c_out=0 immediately.
  - Outputs stay 0 while rst_n is low, even with a=0x1 and b=0x1 applied.
  - Release rst_n -> s=0x2 after the next edge.
- Random regression: at least 10k random a, b, c_in vectors. Each registered output must equal the 33-bit reference sum of the previous cycle's inputs.

Source files
------------

// File: rtl/rca_32_bit_if.sv
// Operand/result bundle for the registered 32-bit ripple-carry adder.
// The master drives operands and carry-in; the slave returns the registered sum.
interface rca_32_bit_if;
  logic [31:0] a;
  logic [31:0] b;
  logic        c_in;
  logic [31:0] s;
  logic        c_out;

  modport master (
    output a,
    output b,
    output c_in,
    input  s,
    input  c_out
  );

  modport slave (
    input  a,
    input  b,
    input  c_in,
    output s,
    output c_out
  );
endinterface

// File: rtl/rca_32_bit.sv
// 32-bit ripple-carry adder built from one-bit full-adder cells.
// The sum and carry-out are registered, giving one cycle of latency.
module rca_fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic p;

  assign p   = a_i ^ b_i;
  assign s_o = p ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & p);
endmodule

module rca_32_bit (
  input  logic               clk,
  input  logic               rst_n,
  rca_32_bit_if.slave        bus_if
);
  logic [32:0] carry;
  logic [31:0] s_d;
  logic        c_out_d;
  logic [31:0] s_q;
  logic        c_out_q;

  assign carry[0] = bus_if.c_in;

  // The carry ripples through every cell; this chain is the critical path.
  for (genvar i = 0; i < 32; i++) begin : g_cell
    rca_fa_cell u_cell (
      .a_i (bus_if.a[i]),
      .b_i (bus_if.b[i]),
      .c_i (carry[i]),
      .s_o (s_d[i]),
      .c_o (carry[i+1])
    );
  end

  assign c_out_d = carry[32];

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= 32'h0;
      c_out_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      c_out_q <= c_out_d;
    end
  end

  assign bus_if.s     = s_q;
  assign bus_if.c_out = c_out_q;
endmodule

// File: tb/tb_rca_32_bit.sv
// Directed and random checks of the registered ripple-carry adder.
// Results are compared as the 33-bit value {c_out, s}.
module tb_rca_32_bit;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  rca_32_bit_if bus ();

  rca_32_bit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got c_out=%0b s=%08h, want c_out=%0b s=%08h",
               tag, obs[32], obs[31:0], exp[32], exp[31:0]);
    end
  endtask

  function automatic logic [32:0] observed();
    return {bus.c_out, bus.s};
  endfunction

  // Drive between edges, then check just after the capturing edge.
  task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic [32:0] exp);
    @(negedge clk);
    bus.a    = a;
    bus.b    = b;
    bus.c_in = cin;
    @(posedge clk);
    #1;
    chk(tag, observed(), exp);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [32:0] exp;
  } vec_t;

  vec_t dir_vecs[7] = '{
    '{32'h4,        32'h5,        1'b0, 33'h0_0000_0009},
    '{32'h4,        32'h5,        1'b1, 33'h0_0000_000A},
    '{32'h6,        32'h7,        1'b0, 33'h0_0000_000D},
    '{32'h6,        32'h7,        1'b1, 33'h0_0000_000E},
    '{32'hFFFFFFFF, 32'h0,        1'b1, 33'h1_0000_0000},
    '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33'h1_FFFF_FFFF},
    '{32'h80000000, 32'h80000000, 1'b0, 33'h1_0000_0000}
  };

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rc;
    logic [32:0] rexp;
    n_vec    = 0;
    n_bad    = 0;
    rst_n    = 1'b1;
    bus.a    = 32'h1234_5678;
    bus.b    = 32'h1111_1111;
    bus.c_in = 1'b1;

    #2 rst_n = 1'b0;
    #1 chk("reset_async_clear", observed(), 33'h0);
    @(posedge clk);
    @(posedge clk);
    #1 chk("reset_hold", observed(), 33'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (dir_vecs[i])
      apply($sformatf("dir%0d", i), dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].cin, dir_vecs[i].exp);

    // Mid-cycle operand change must not reach the outputs before an edge.
    apply("pre_hold", 32'h6, 32'h7, 1'b1, 33'h0_0000_000E);
    #2;
    bus.a = 32'h100;
    bus.b = 32'h23;
    bus.c_in = 1'b0;
    #1 chk("hold_no_edge", observed(), 33'h0_0000_000E);
    @(posedge clk);
    #1 chk("hold_after_edge", observed(), 33'h0_0000_0123);

    // Back-to-back: each edge presents exactly the previous cycle's sum.
    apply("b2b0", 32'h0000_0001, 32'h0000_0002, 1'b0, 33'h0_0000_0003);
    apply("b2b1", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_8000_0000);
    apply("b2b2", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 33'h1_0000_0000);
    apply("b2b3", 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 33'h0_DEAD_BEEF);

    // Asynchronous reset between edges.
    apply("pre_rst", 32'h6, 32'h7, 1'b1, 33'h0_0000_000E);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_cycle", observed(), 33'h0);
    bus.a = 32'h1;
    bus.b = 32'h1;
    bus.c_in = 1'b0;
    @(posedge clk);
    #1 chk("rst_low_hold", observed(), 33'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rst_release", observed(), 33'h0_0000_0002);

    // Random regression against a 33-bit reference sum.
    for (int i = 0; i < 10000; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      rc   = 1'($urandom_range(0, 1));
      rexp = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
      apply("rand", ra, rb, rc, rexp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
